di_fifo_read_terminal: RTL

// - DI read terminal: buffers words from a same-clock user producer and serves them to HostInterface

---
 rtl/di_fifo_read_terminal.sv | 139 +++++++++++++
 1 files changed

// File: rtl/di_fifo_read_terminal.sv
// DI read terminal: FIFO between a same-clock producer and HostInterface data-register reads.
// Define DI_FIFO_STATUS_EN to add a status register at REG_ADDR+1 (flags + count, read-to-clear).
module di_fifo_read_terminal #(
  parameter int          DATA_WIDTH = 16,
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [15:0] EP_ADDR    = 16'h0,
  parameter logic [15:0] REG_ADDR   = 16'h0
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic [15:0]           diEpAddr,
  input  logic [15:0]           diRegAddr,
  input  logic                  diRead,
  input  logic                  diReset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  rdwr_ready,
  output logic [DATA_WIDTH-1:0] diRegDataOut
);
  localparam int              DEPTH      = 1 << DEPTH_LOG2;
  localparam int              CW         = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]   DEPTH_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0]   RDY_THRESH = CW'(3);

  localparam logic [1:0] ST_DESEL = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_SERVE = 2'd2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  rdy_q, rdy_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [1:0]            state_q, state_d;

  logic rst, ep_hit, sel_data, sel_stat, sel, stat_rd, push, pop;

  assign rst      = !resetb || diReset;
  assign ep_hit   = (diEpAddr == EP_ADDR);
  assign sel_data = ep_hit && (diRegAddr == REG_ADDR);
`ifdef DI_FIFO_STATUS_EN
  assign sel_stat = ep_hit && (diRegAddr == REG_ADDR + 16'd1);
`else
  assign sel_stat = 1'b0;
`endif
  assign sel      = sel_data || sel_stat;
  assign stat_rd  = sel_stat && diRead;

  assign full     = (count_q == DEPTH_CNT);
  assign push     = wr_en && !full;
  assign pop      = sel_data && diRead && (count_q != '0);

  assign count_d  = count_q + CW'(push) - CW'(pop);
  assign rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop);
  assign wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(push);

  // A status read clears the flags, but an event in the same cycle re-arms them.
  always_comb begin
    ovf_d = (ovf_q && !stat_rd) || (wr_en && full);
    unf_d = (unf_q && !stat_rd) || (sel_data && diRead && (count_q == '0));
  end

`ifdef DI_FIFO_STATUS_EN
  logic [DATA_WIDTH-1:0] stat_word;
  always_comb begin
    stat_word                 = '0;
    stat_word[DATA_WIDTH-1]   = ovf_q;
    stat_word[DATA_WIDTH-2]   = unf_q;
    stat_word[DEPTH_LOG2:0]   = count_q;
  end
`endif

  always_comb begin
    dout_d = dout_q;
    if (!sel)
      dout_d = '0;
    else if (sel_data && diRead)
      dout_d = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
`ifdef DI_FIFO_STATUS_EN
    else if (stat_rd)
      dout_d = stat_word;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DESEL: if (sel) state_d = ST_ARM;
      ST_ARM:   state_d = sel ? ST_SERVE : ST_DESEL;
      ST_SERVE: if (!sel) state_d = ST_DESEL;
      default:  state_d = ST_DESEL;
    endcase
  end

  // Threshold of 3 leaves room for the two reads already in flight when the host sees the drop.
  always_comb begin
    rdy_d = 1'b0;
    if (state_q == ST_SERVE && sel)
      rdy_d = sel_stat || (count_d >= RDY_THRESH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rdy_q    <= 1'b0;
      dout_q   <= '0;
      state_q  <= ST_DESEL;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      rdy_q    <= rdy_d;
      dout_q   <= dout_d;
      state_q  <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst)
      mem_q[wr_ptr_q] <= wr_data;
  end

  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign rdwr_ready   = rdy_q;
  assign diRegDataOut = dout_q;
endmodule
